// File: rtl/regfile_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_arbiter
//
// Round-robin arbiter and access sequencer for a shared DEPTH x WIDTH
// register array. Up to NREQ requesters post single read or write
// transactions. The block picks one winner per transaction, performs the
// array access and returns a one-cycle grant pulse, plus read data for reads.
//
// Transaction timing (one transaction every two cycles at most):
//   edge E0 (IDLE) : winner chosen and its request fields captured
//   edge E1 (XFER) : array accessed; gnt/rid/rvalid/rdata registered
//   cycle after E1 : gnt visible for one cycle, busy back to 0
//
// Addresses at or above DEPTH are out of range. Writes to them are dropped.
// Reads from them return 0 and still complete with gnt and rvalid.
//
// Optional feature, enabled by defining REGFILE_ARB_LOCK_EN:
//   Adds the input port lock and the parameter LOCK_MAX. When a winner has its
//   lock bit set at capture, it keeps top priority for up to LOCK_MAX
//   consecutive grants.
//
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   synchronous active-low reset; clears the array as well
//   req     in   [NREQ]        per-requester request level
//   we      in   [NREQ]        per-requester op: 1 = write, 0 = read
//   addr    in   [NREQ*AW]     requester k uses bits [k*AW +: AW]
//   wdata   in   [NREQ*WIDTH]  requester k uses bits [k*WIDTH +: WIDTH]
//   lock    in   [NREQ]        (REGFILE_ARB_LOCK_EN only) hold priority
//   gnt     out  [NREQ]        one-hot completion pulse
//   rvalid  out  read data valid, coincides with gnt for reads
//   rdata   out  [WIDTH]       read data; holds its value between reads
//   rid     out  [IW]          index of the requester completing
//   busy    out  high for the cycle the transfer is in flight
// ---------------------------------------------------------------------------
module regfile_arbiter #(
  parameter int NREQ  = 4,
  parameter int DEPTH = 32,
  parameter int WIDTH = 8,
  parameter int AW    = 5,
  parameter int IW    = 2
`ifdef REGFILE_ARB_LOCK_EN
  ,
  parameter int LOCK_MAX = 4
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       we,
  input  logic [NREQ*AW-1:0]    addr,
  input  logic [NREQ*WIDTH-1:0] wdata,
`ifdef REGFILE_ARB_LOCK_EN
  input  logic [NREQ-1:0]       lock,
`endif
  output logic [NREQ-1:0]       gnt,
  output logic                  rvalid,
  output logic [WIDTH-1:0]      rdata,
  output logic [IW-1:0]         rid,
  output logic                  busy
);

  // Sized copies of the integer parameters, for width-matched compares.
  localparam logic [IW:0] NREQ_W  = (IW+1)'(NREQ);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_XFER = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_capture;
  logic             w_exec;

  // Priority pointer and captured transaction.
  logic [IW-1:0]    r_ptr;
  logic [IW-1:0]    r_cap_id;
  logic             r_cap_we;
  logic [AW-1:0]    r_cap_addr;
  logic [WIDTH-1:0] r_cap_wdata;

  // Registered outputs.
  logic [NREQ-1:0]  r_gnt;
  logic             r_rvalid;
  logic [WIDTH-1:0] r_rdata;
  logic [IW-1:0]    r_rid;
  logic             r_busy;

  logic [WIDTH-1:0] r_mem [DEPTH];

  logic [AW-1:0]    w_addr_arr  [NREQ];
  logic [WIDTH-1:0] w_wdata_arr [NREQ];
  logic [NREQ-1:0]  w_req_rot;
  logic             w_found;
  logic [IW-1:0]    w_winner;
  logic [IW:0]      w_sum;
  logic [IW:0]      w_id_sum;
  logic [IW-1:0]    w_ptr_adv;
  logic [IW-1:0]    w_ptr_nxt;
  logic             w_in_range;
  logic [WIDTH-1:0] w_rd;

`ifdef REGFILE_ARB_LOCK_EN
  localparam int          CW     = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] LMAX_W = CW'(LOCK_MAX);

  logic             r_cap_lock;
  logic [IW-1:0]    r_last_id;
  logic [CW-1:0]    r_lock_cnt;
  logic [CW-1:0]    w_cnt_nxt;
`endif

  // Split the flattened request buses into per-requester fields.
  always_comb begin : unpack
    for (int i = 0; i < NREQ; i++) begin
      w_addr_arr[i]  = addr[i*AW +: AW];
      w_wdata_arr[i] = wdata[i*WIDTH +: WIDTH];
    end
  end

  // Rotate the requests so that bit 0 is the requester at the pointer.
  // The first set bit i then maps back to requester (ptr + i) mod NREQ.
  assign w_req_rot = NREQ'({req, req} >> r_ptr);

  always_comb begin : arbitrate
    // NOTE: every variable written in this combinational block gets a value
    // before any condition. A variable left unassigned on some path would
    // have to hold its old value, and that infers a latch.
    w_found  = 1'b0;
    w_winner = '0;
    w_sum    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && w_req_rot[i]) begin
        w_found  = 1'b1;
        w_sum    = {1'b0, r_ptr} + (IW+1)'(i);
        w_winner = (w_sum >= NREQ_W) ? IW'(w_sum - NREQ_W) : w_sum[IW-1:0];
      end
    end
  end

  // FSM next-state logic and control strobes.
  always_comb begin : fsm_next
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_exec      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_capture   = 1'b1;
          w_state_nxt = S_XFER;
        end
      end
      S_XFER: begin
        w_exec      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin : fsm_state
    // NOTE: sequential state is updated with non-blocking assignments, so
    // every register samples the values from before the clock edge.
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Pointer update after a grant: normally the requester after the winner.
  always_comb begin : ptr_next
    w_id_sum  = {1'b0, r_cap_id} + (IW+1)'(1);
    w_ptr_adv = (w_id_sum >= NREQ_W) ? '0 : w_id_sum[IW-1:0];
`ifdef REGFILE_ARB_LOCK_EN
    // Count consecutive grants to the same requester; saturate at LOCK_MAX
    // so a lone requester that is granted repeatedly cannot wrap the count.
    if (r_cap_id != r_last_id)   w_cnt_nxt = CW'(1);
    else if (r_lock_cnt < LMAX_W) w_cnt_nxt = r_lock_cnt + CW'(1);
    else                         w_cnt_nxt = r_lock_cnt;
    w_ptr_nxt = (r_cap_lock && (w_cnt_nxt < LMAX_W)) ? r_cap_id : w_ptr_adv;
`else
    w_ptr_nxt = w_ptr_adv;
`endif
  end

  // Capture the winner's request fields at the IDLE edge. Later changes on
  // the inputs do not affect the captured transaction.
  always_ff @(posedge clk) begin : capture
    if (!rst_n) begin
      r_cap_id    <= '0;
      r_cap_we    <= 1'b0;
      r_cap_addr  <= '0;
      r_cap_wdata <= '0;
`ifdef REGFILE_ARB_LOCK_EN
      r_cap_lock  <= 1'b0;
`endif
    end else if (w_capture) begin
      r_cap_id    <= w_winner;
      r_cap_we    <= we[w_winner];
      r_cap_addr  <= w_addr_arr[w_winner];
      r_cap_wdata <= w_wdata_arr[w_winner];
`ifdef REGFILE_ARB_LOCK_EN
      r_cap_lock  <= lock[w_winner];
`endif
    end
  end

  assign w_in_range = ({1'b0, r_cap_addr} < DEPTH_W);
  assign w_rd       = w_in_range ? r_mem[r_cap_addr] : '0;

  // Storage array. Reset forces every entry to zero. A write still in XFER
  // when reset is asserted is lost, because the reset branch takes priority.
  always_ff @(posedge clk) begin : mem_write
    // NOTE: the array has to be cleared on reset, so it is built from
    // resettable flops rather than a RAM macro, and it is cleared in a loop.
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_exec && r_cap_we && w_in_range) begin
      r_mem[r_cap_addr] <= r_cap_wdata;
    end
  end

  // Completion signalling and pointer advance.
  always_ff @(posedge clk) begin : complete
    if (!rst_n) begin
      r_ptr    <= '0;
      r_gnt    <= '0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rid    <= '0;
      r_busy   <= 1'b0;
    end else begin
      r_gnt    <= '0;
      r_rvalid <= 1'b0;
      r_busy   <= (w_state_nxt == S_XFER);
      if (w_exec) begin
        r_gnt <= {{(NREQ-1){1'b0}}, 1'b1} << r_cap_id;
        r_rid <= r_cap_id;
        r_ptr <= w_ptr_nxt;
        if (!r_cap_we) begin
          r_rvalid <= 1'b1;
          r_rdata  <= w_rd;
        end
      end
    end
  end

`ifdef REGFILE_ARB_LOCK_EN
  always_ff @(posedge clk) begin : lock_track
    if (!rst_n) begin
      r_last_id  <= '0;
      r_lock_cnt <= '0;
    end else if (w_exec) begin
      r_last_id  <= r_cap_id;
      r_lock_cnt <= w_cnt_nxt;
    end
  end
`endif

  assign gnt    = r_gnt;
  assign rvalid = r_rvalid;
  assign rdata  = r_rdata;
  assign rid    = r_rid;
  assign busy   = r_busy;

endmodule

// File: tb/tb_regfile_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_arbiter
//
// Testbench for regfile_arbiter with NREQ=4, DEPTH=20, WIDTH=8, AW=5, IW=2.
// The DEPTH of 20 makes addresses 20..31 out of range.
//
// The bench has four parts:
//   1. A table of single transactions with hand-computed expected results.
//   2. Hand-written sequences: round robin, and reset during XFER.
//   3. Random transactions checked against a transaction-level model.
//   4. The lock sequence, built only when REGFILE_ARB_LOCK_EN is defined.
// ---------------------------------------------------------------------------
module tb_regfile_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  we;
  logic [19:0] addr;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic        rvalid;
  logic [7:0]  rdata;
  logic [1:0]  rid;
  logic        busy;
`ifdef REGFILE_ARB_LOCK_EN
  logic [3:0]  lock;
`endif

  regfile_arbiter #(
    .NREQ (4),
    .DEPTH(20),
    .WIDTH(8),
    .AW   (5),
    .IW   (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
`ifdef REGFILE_ARB_LOCK_EN
    .lock  (lock),
`endif
    .gnt   (gnt),
    .rvalid(rvalid),
    .rdata (rdata),
    .rid   (rid),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level reference model: array contents, priority pointer and
  // the last read data seen.
  logic [7:0] m_mem [32];
  int         m_ptr;
  logic [7:0] m_rdata;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = 8'h00;
    m_ptr   = 0;
    m_rdata = 8'h00;
  endtask

  task automatic model_round(input logic [3:0] rq, input logic [3:0] wm,
                             input logic [19:0] a, input logic [31:0] wd,
                             output logic [3:0] eg, output logic [1:0] eid,
                             output logic erv, output logic [7:0] erd);
    int k;
    int ak;
    k   = -1;
    eg  = 4'b0000;
    eid = 2'd0;
    erv = 1'b0;
    for (int i = 0; i < 4; i++)
      if (k < 0 && rq[(m_ptr + i) % 4]) k = (m_ptr + i) % 4;
    if (k >= 0) begin
      eg  = 4'(1 << k);
      eid = 2'(k);
      ak  = int'(a[k*5 +: 5]);
      if (wm[k]) begin
        if (ak < 20) m_mem[ak] = wd[k*8 +: 8];
      end else begin
        erv     = 1'b1;
        m_rdata = (ak < 20) ? m_mem[ak] : 8'h00;
      end
      m_ptr = (k + 1) % 4;
    end
    erd = m_rdata;
  endtask

  // Run one arbitration round, starting from IDLE. The requests are applied,
  // the bench waits out the two-cycle latency, checks the results, and then
  // drops the requests in the cycle that gnt is visible.
  task automatic do_round(input string name, input logic [3:0] rq, input logic [3:0] wm,
                          input logic [19:0] a, input logic [31:0] wd,
                          input logic [3:0] eg, input logic [1:0] eid,
                          input logic erv, input logic [7:0] erd);
    req = rq; we = wm; addr = a; wdata = wd;
    @(posedge clk); #1;
    check({name, ".busy_xfer"}, 32'(busy), 32'(rq != 4'b0000));
    check({name, ".no_early_gnt"}, 32'(gnt), 32'h0);
    if (rq != 4'b0000) begin
      @(posedge clk); #1;
    end
    check({name, ".gnt"}, 32'(gnt), 32'(eg));
    check({name, ".rvalid"}, 32'(rvalid), 32'(erv));
    check({name, ".rdata"}, 32'(rdata), 32'(erd));
    check({name, ".busy_done"}, 32'(busy), 32'h0);
    if (eg != 4'b0000) check({name, ".rid"}, 32'(rid), 32'(eid));
    req = 4'b0000;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = 4'b0000;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic [3:0] rq;
    logic [3:0] wm;
    logic [4:0] a;
    logic [7:0] wd;
    logic [3:0] exp_gnt;
    logic [1:0] exp_rid;
    logic       exp_rv;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vecs[12];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : main
    logic [3:0]  eg;
    logic [1:0]  eid;
    logic        erv;
    logic [7:0]  erd;
    logic [3:0]  rq;
    logic [3:0]  wm;
    logic [19:0] ra;
    logic [31:0] rw;

    // Each entry drives the same address and data on all four requesters.
    // The expected values follow from reset: pointer 0, array all zero.
    vecs[0]  = '{4'b0001, 4'b0001, 5'd5,  8'hA5, 4'b0001, 2'd0, 1'b0, 8'h00};
    vecs[1]  = '{4'b0100, 4'b0000, 5'd5,  8'h00, 4'b0100, 2'd2, 1'b1, 8'hA5};
    vecs[2]  = '{4'b0011, 4'b0000, 5'd5,  8'h00, 4'b0001, 2'd0, 1'b1, 8'hA5};
    vecs[3]  = '{4'b0011, 4'b0011, 5'd25, 8'hFF, 4'b0010, 2'd1, 1'b0, 8'hA5};
    vecs[4]  = '{4'b0011, 4'b0000, 5'd25, 8'h00, 4'b0001, 2'd0, 1'b1, 8'h00};
    vecs[5]  = '{4'b0011, 4'b0000, 5'd5,  8'h00, 4'b0010, 2'd1, 1'b1, 8'hA5};
    vecs[6]  = '{4'b1000, 4'b1000, 5'd19, 8'h5A, 4'b1000, 2'd3, 1'b0, 8'hA5};
    vecs[7]  = '{4'b1111, 4'b0000, 5'd19, 8'h00, 4'b0001, 2'd0, 1'b1, 8'h5A};
    vecs[8]  = '{4'b1111, 4'b0000, 5'd0,  8'h00, 4'b0010, 2'd1, 1'b1, 8'h00};
    vecs[9]  = '{4'b0000, 4'b0000, 5'd0,  8'h00, 4'b0000, 2'd0, 1'b0, 8'h00};
    vecs[10] = '{4'b1100, 4'b0100, 5'd20, 8'h77, 4'b0100, 2'd2, 1'b0, 8'h00};
    vecs[11] = '{4'b1100, 4'b0000, 5'd20, 8'h00, 4'b1000, 2'd3, 1'b1, 8'h00};

    req = 4'b0000; we = 4'b0000; addr = '0; wdata = '0;
`ifdef REGFILE_ARB_LOCK_EN
    lock = 4'b0000;
`endif
    do_reset();

    check("reset.gnt",    32'(gnt),    32'h0);
    check("reset.rvalid", 32'(rvalid), 32'h0);
    check("reset.rdata",  32'(rdata),  32'h0);
    check("reset.rid",    32'(rid),    32'h0);
    check("reset.busy",   32'(busy),   32'h0);

    // Table-driven transactions. The model follows along so that it stays in
    // step for the later phases.
    for (int i = 0; i < 12; i++) begin
      model_round(vecs[i].rq, vecs[i].wm, {4{vecs[i].a}}, {4{vecs[i].wd}}, eg, eid, erv, erd);
      do_round($sformatf("vec%0d", i), vecs[i].rq, vecs[i].wm, {4{vecs[i].a}}, {4{vecs[i].wd}},
               vecs[i].exp_gnt, vecs[i].exp_rid, vecs[i].exp_rv, vecs[i].exp_rd);
    end

    // Round robin: all four requesters read addr 19, starting from pointer 0.
    // The expected order is 0, 1, 2, 3, 0.
    for (int i = 0; i < 5; i++) begin
      model_round(4'b1111, 4'b0000, {4{5'd19}}, 32'h0, eg, eid, erv, erd);
      do_round($sformatf("rr%0d", i), 4'b1111, 4'b0000, {4{5'd19}}, 32'h0,
               4'(1 << (i % 4)), 2'(i % 4), 1'b1, 8'h5A);
    end

    // Random transactions, checked against the model.
    for (int i = 0; i < 80; i++) begin
      rq = 4'($urandom_range(0, 15));
      wm = 4'($urandom_range(0, 15));
      for (int k = 0; k < 4; k++) ra[k*5 +: 5] = 5'($urandom_range(0, 31));
      rw = $urandom;
      model_round(rq, wm, ra, rw, eg, eid, erv, erd);
      do_round($sformatf("rand%0d", i), rq, wm, ra, rw, eg, eid, erv, erd);
    end

    // Read back every in-range entry. This shows that the dropped
    // out-of-range writes did not alias onto entries 0..19.
    for (int i = 0; i < 20; i++) begin
      rq = 4'(1 << (i % 4));
      ra = {4{5'(i)}};
      model_round(rq, 4'b0000, ra, 32'h0, eg, eid, erv, erd);
      do_round($sformatf("sweep%0d", i), rq, 4'b0000, ra, 32'h0, eg, eid, erv, erd);
    end

    // Reset during XFER: the captured write must not be committed.
    req = 4'b0001; we = 4'b0001; addr = {4{5'd3}}; wdata = {4{8'h3C}};
    @(posedge clk); #1;
    check("rst_mid.busy_xfer", 32'(busy), 32'h1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_mid.gnt",  32'(gnt),  32'h0);
    check("rst_mid.busy", 32'(busy), 32'h0);
    req = 4'b0000;
    rst_n = 1'b1;
    model_reset();
    model_round(4'b0001, 4'b0000, {4{5'd3}}, 32'h0, eg, eid, erv, erd);
    do_round("rst_mid.read3", 4'b0001, 4'b0000, {4{5'd3}}, 32'h0, 4'b0001, 2'd0, 1'b1, 8'h00);

`ifdef REGFILE_ARB_LOCK_EN
    // Lock: requester 0 holds lock. It is granted four times in a row, then
    // requester 1 is granted, then requester 0 again.
    do_reset();
    lock = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      eg = (i == 4) ? 4'b0010 : 4'b0001;
      do_round($sformatf("lock%0d", i), 4'b0011, 4'b0000, {4{5'd0}}, 32'h0,
               eg, (i == 4) ? 2'd1 : 2'd0, 1'b1, 8'h00);
    end
    lock = 4'b0000;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
